// File: rtl/level_limiter_mc.sv
// Multi-channel level limiter: clamps each signed channel sample to a runtime
// programmable width through a 2-stage valid/ready pipeline, and keeps
// per-channel saturating clip counters and input peak-magnitude registers.
module level_limiter_mc #(
   parameter int DATA_WIDTH   = 24,
   parameter int NUM_CHANNELS = 2,
   parameter int CNT_WIDTH    = 16
) (
   input  logic                               i_clk,
   input  logic                               i_reset,
   input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] iS_data,
   input  logic                               i_valid,
   output logic                               o_ready,
   input  logic [4:0]                         i_limit_bits,
   input  logic                               i_symmetric,
   input  logic                               i_clear_stats,
   output logic [NUM_CHANNELS*DATA_WIDTH-1:0] oS_data,
   output logic                               o_valid,
   input  logic                               i_ready,
   output logic [NUM_CHANNELS-1:0]            o_clip,
   output logic [NUM_CHANNELS*CNT_WIDTH-1:0]  o_clip_count,
   output logic [NUM_CHANNELS*DATA_WIDTH-1:0] o_peak
);

   // One extra bit so hi/lo for L == DATA_WIDTH never overflow.
   localparam int EW = DATA_WIDTH + 1;
   localparam logic [5:0]           MAX_L   = 6'(DATA_WIDTH);
   localparam logic signed [EW-1:0] ONE_E   = EW'(1);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

   typedef logic signed [DATA_WIDTH-1:0] sample_t;

   logic advance;

   logic [5:0]           lim_req, lim_eff;
   logic signed [EW-1:0] half, hi_ext, lo_ext;

   sample_t              x_in  [NUM_CHANNELS];
   logic signed [EW-1:0] x_ext [NUM_CHANNELS];
   logic [NUM_CHANNELS-1:0] above_c, below_c;

   logic                    s1_valid;
   sample_t                 s1_x  [NUM_CHANNELS];
   sample_t                 s1_hi [NUM_CHANNELS];
   sample_t                 s1_lo [NUM_CHANNELS];
   logic [NUM_CHANNELS-1:0] s1_above, s1_below;

   sample_t                 limited [NUM_CHANNELS];
   logic [DATA_WIDTH-1:0]   abs_x   [NUM_CHANNELS];
   logic [NUM_CHANNELS-1:0] clip_c;

   sample_t               out_q    [NUM_CHANNELS];
   logic [CNT_WIDTH-1:0]  clip_cnt [NUM_CHANNELS];
   logic [DATA_WIDTH-1:0] peak     [NUM_CHANNELS];

   // Whole pipeline moves together whenever the output slot is free or draining.
   assign advance = !o_valid || i_ready;
   assign o_ready = advance;

   // Limit window shared by all channels: clamp L to 2..DATA_WIDTH, derive hi/lo.
   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      lim_req = {1'b0, i_limit_bits};
      lim_eff = lim_req;
      if (lim_req < 6'd2)
         lim_eff = 6'd2;
      else if (lim_req > MAX_L)
         lim_eff = MAX_L;
      half   = ONE_E <<< (lim_eff - 6'd1);
      hi_ext = half - ONE_E;
      lo_ext = i_symmetric ? -hi_ext : -half;
   end

   // Per-channel range comparison on the sign-extended input sample.
   always_comb begin
      above_c = '0;
      below_c = '0;
      x_in    = '{default: '0};
      x_ext   = '{default: '0};
      for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
         x_in[ch]    = iS_data[ch*DATA_WIDTH +: DATA_WIDTH];
         x_ext[ch]   = {x_in[ch][DATA_WIDTH-1], x_in[ch]};
         above_c[ch] = x_ext[ch] > hi_ext;
         below_c[ch] = x_ext[ch] < lo_ext;
      end
   end

   // Stage 1 register: capture sample, its window and the compare results.
   // NOTE: only the valid bit is reset; payload registers are qualified by it.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         s1_valid <= 1'b0;
      end else if (advance) begin
         s1_valid <= i_valid;
         s1_above <= above_c;
         s1_below <= below_c;
         for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            s1_x[ch]  <= x_in[ch];
            s1_hi[ch] <= hi_ext[DATA_WIDTH-1:0];
            s1_lo[ch] <= lo_ext[DATA_WIDTH-1:0];
         end
      end
   end

   // Stage 2 selection and raw-input magnitude for peak tracking.
   always_comb begin
      clip_c  = s1_above | s1_below;
      limited = '{default: '0};
      abs_x   = '{default: '0};
      for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
         if (s1_above[ch])
            limited[ch] = s1_hi[ch];
         else if (s1_below[ch])
            limited[ch] = s1_lo[ch];
         else
            limited[ch] = s1_x[ch];
         // Two's complement negate as unsigned: most negative maps to 2^(DW-1).
         abs_x[ch] = s1_x[ch][DATA_WIDTH-1] ? (~s1_x[ch] + DATA_WIDTH'(1)) : s1_x[ch];
      end
   end

   // Stage 2 register: output sample set, held while stalled.
   // NOTE: sequential state uses non-blocking assignments; comb logic uses blocking.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         o_valid <= 1'b0;
         o_clip  <= '0;
         out_q   <= '{default: '0};
      end else if (advance) begin
         o_valid <= s1_valid;
         o_clip  <= clip_c;
         out_q   <= limited;
      end
   end

   // Statistics: update on each valid stage-1 to stage-2 move; clear wins.
   always_ff @(posedge i_clk) begin
      if (i_reset || i_clear_stats) begin
         clip_cnt <= '{default: '0};
         peak     <= '{default: '0};
      end else if (advance && s1_valid) begin
         for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            if (clip_c[ch] && (clip_cnt[ch] != CNT_MAX))
               clip_cnt[ch] <= clip_cnt[ch] + CNT_WIDTH'(1);
            if (abs_x[ch] > peak[ch])
               peak[ch] <= abs_x[ch];
         end
      end
   end

   for (genvar ch = 0; ch < NUM_CHANNELS; ch++) begin : g_pack
      assign oS_data[ch*DATA_WIDTH +: DATA_WIDTH]     = out_q[ch];
      assign o_clip_count[ch*CNT_WIDTH +: CNT_WIDTH]  = clip_cnt[ch];
      assign o_peak[ch*DATA_WIDTH +: DATA_WIDTH]      = peak[ch];
   end

endmodule

// File: tb/tb_level_limiter_mc.sv
// Scoreboard bench for level_limiter_mc: directed vectors push hand-computed
// expected outputs; an independent monitor pops them as outputs transfer.
module tb_level_limiter_mc;

   localparam int DW = 24;
   localparam int NC = 2;
   localparam int CW = 4;

   typedef struct {
      logic [DW-1:0] d0;
      logic [DW-1:0] d1;
      logic [1:0]    clip;
   } exp_t;

   logic             i_clk = 1'b0;
   logic             i_reset = 1'b1;
   logic [NC*DW-1:0] iS_data = '0;
   logic             i_valid = 1'b0;
   logic             o_ready;
   logic [4:0]       i_limit_bits = 5'd16;
   logic             i_symmetric = 1'b0;
   logic             i_clear_stats = 1'b0;
   logic [NC*DW-1:0] oS_data;
   logic             o_valid;
   logic             i_ready = 1'b1;
   logic [NC-1:0]    o_clip;
   logic [NC*CW-1:0] o_clip_count;
   logic [NC*DW-1:0] o_peak;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_err = 0;

   level_limiter_mc #(.DATA_WIDTH(DW), .NUM_CHANNELS(NC), .CNT_WIDTH(CW)) dut (
      .i_clk(i_clk), .i_reset(i_reset), .iS_data(iS_data), .i_valid(i_valid),
      .o_ready(o_ready), .i_limit_bits(i_limit_bits), .i_symmetric(i_symmetric),
      .i_clear_stats(i_clear_stats), .oS_data(oS_data), .o_valid(o_valid),
      .i_ready(i_ready), .o_clip(o_clip), .o_clip_count(o_clip_count), .o_peak(o_peak)
   );

   always #5 i_clk = ~i_clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   // Present one sample set and wait (bounded) for its transfer.
   task automatic send(input int x0, input int x1, input int lim, input bit sym,
                       input int e0, input int e1, input logic [1:0] c);
      exp_t e;
      bit   acc;
      int   n;
      e.d0 = DW'(e0);
      e.d1 = DW'(e1);
      e.clip = c;
      exp_q.push_back(e);
      iS_data      = {DW'(x1), DW'(x0)};
      i_limit_bits = 5'(lim);
      i_symmetric  = sym;
      i_valid      = 1'b1;
      acc = 1'b0;
      n = 0;
      while (!acc && n < 100) begin
         @(negedge i_clk);
         acc = o_ready;
         tick();
         n++;
      end
      check("send_accept", {63'd0, acc}, 64'd1);
      i_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         tick();
         n++;
      end
      check("drain_empty", 64'(exp_q.size()), 64'd0);
      repeat (2) tick();
   endtask

   task automatic clear_stats();
      i_clear_stats = 1'b1;
      tick();
      i_clear_stats = 1'b0;
   endtask

   task automatic check_stats(input int c0, input int c1, input int p0, input int p1);
      check("cnt_ch0", 64'(o_clip_count[CW-1:0]), 64'(c0));
      check("cnt_ch1", 64'(o_clip_count[2*CW-1:CW]), 64'(c1));
      check("peak_ch0", 64'(o_peak[DW-1:0]), 64'(p0));
      check("peak_ch1", 64'(o_peak[2*DW-1:DW]), 64'(p1));
   endtask

   // Monitor: handshake rule, stall stability and scoreboard comparison.
   initial begin : monitor
      exp_t             e;
      bit               stalled = 1'b0;
      logic [NC*DW-1:0] held_data = '0;
      logic [NC-1:0]    held_clip = '0;
      forever begin
         @(negedge i_clk);
         check("ready_rule", {63'd0, o_ready}, {63'd0, (!o_valid || i_ready)});
         if (stalled) begin
            check("hold_valid", {63'd0, o_valid}, 64'd1);
            check("hold_data", 64'(oS_data), 64'(held_data));
            check("hold_clip", 64'(o_clip), 64'(held_clip));
         end
         if (o_valid && i_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_output", {63'd0, o_valid}, 64'd0);
            end else begin
               e = exp_q.pop_front();
               check("out_ch0", 64'(oS_data[DW-1:0]), 64'(e.d0));
               check("out_ch1", 64'(oS_data[2*DW-1:DW]), 64'(e.d1));
               check("out_clip", 64'(o_clip), 64'(e.clip));
            end
         end
         stalled   = o_valid && !i_ready && !i_reset;
         held_data = oS_data;
         held_clip = o_clip;
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
      $fatal(1, "watchdog expired");
   end

   logic pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

   initial begin : stimulus
      repeat (3) tick();
      i_reset = 1'b0;
      check("rst_o_valid", {63'd0, o_valid}, 64'd0);
      check("rst_o_ready", {63'd0, o_ready}, 64'd1);
      check("rst_data", 64'(oS_data), 64'd0);
      check("rst_clip", 64'(o_clip), 64'd0);
      check_stats(0, 0, 0, 0);

      // 1: passthrough at L=16, ramp covering both range ends, with latency check.
      send(-32768, 32767, 16, 0, -32768, 32767, 2'b00);
      check("lat1_valid_low", {63'd0, o_valid}, 64'd0);
      tick();
      check("lat2_valid_high", {63'd0, o_valid}, 64'd1);
      for (int k = 1; k < 256; k++) begin
         int x;
         x = -32768 + k * 257;
         send(x, -x - 1, 16, 0, x, -x - 1, 2'b00);
      end
      drain();
      check_stats(0, 0, 32768, 32768);

      // 2: clipping, asymmetric then symmetric.
      clear_stats();
      send(40000, -40000, 16, 0, 32767, -32768, 2'b11);
      drain();
      check_stats(1, 1, 40000, 40000);
      send(40000, -40000, 16, 1, 32767, -32767, 2'b11);
      drain();
      check_stats(2, 2, 40000, 40000);

      // 3: backpressure with i_ready pattern 1,0,0,1; L=8 window is -128..127.
      fork
         for (int k = 0; k < 10; k++) begin
            if (k < 5) send(k * 30, -k * 30, 8, 0, k * 30, -k * 30, 2'b00);
            else       send(k * 30, -k * 30, 8, 0, 127, -128, 2'b11);
         end
         for (int i = 0; i < 40; i++) begin
            i_ready = pat[i % 4];
            tick();
         end
      join
      i_ready = 1'b1;
      drain();

      // 4: counter saturation (CW=4), L=1 behaves as L=2, clear beats update.
      clear_stats();
      for (int k = 0; k < 20; k++) send(5, -5, 1, 0, 1, -2, 2'b11);
      drain();
      check_stats(15, 15, 5, 5);
      send(5, -5, 1, 0, 1, -2, 2'b11);
      i_clear_stats = 1'b1;
      tick();
      i_clear_stats = 1'b0;
      drain();
      check_stats(0, 0, 0, 0);

      // 5: peak hold and full-scale edge values.
      send(5, 0, 24, 0, 5, 0, 2'b00);
      send(-300, 0, 24, 0, -300, 0, 2'b00);
      send(200, 0, 24, 0, 200, 0, 2'b00);
      drain();
      check_stats(0, 0, 300, 0);
      send(-8388608, 0, 24, 0, -8388608, 0, 2'b00);
      drain();
      check_stats(0, 0, 8388608, 0);
      send(-8388608, 8388607, 31, 0, -8388608, 8388607, 2'b00);
      send(7, -8388608, 24, 1, 7, -8388607, 2'b10);
      drain();
      check_stats(0, 1, 8388608, 8388608);

      // 6: reset with both stages full, then post-reset latency.
      clear_stats();
      i_ready = 1'b0;
      send(100, 0, 4, 0, 7, 0, 2'b01);
      send(3, 0, 4, 0, 3, 0, 2'b00);
      check("full_o_valid", {63'd0, o_valid}, 64'd1);
      check_stats(1, 0, 100, 0);
      i_reset = 1'b1;
      exp_q.delete();
      tick();
      check("mid_rst_o_valid", {63'd0, o_valid}, 64'd0);
      check("mid_rst_clip", 64'(o_clip), 64'd0);
      check_stats(0, 0, 0, 0);
      i_reset = 1'b0;
      i_ready = 1'b1;
      tick();
      check("post_rst_o_valid", {63'd0, o_valid}, 64'd0);
      check("post_rst_o_ready", {63'd0, o_ready}, 64'd1);
      send(-9, 9, 4, 1, -7, 7, 2'b11);
      check("post_lat1_valid_low", {63'd0, o_valid}, 64'd0);
      tick();
      check("post_lat2_valid_high", {63'd0, o_valid}, 64'd1);
      drain();
      check_stats(1, 1, 9, 9);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
